// File: rtl/byte_word_packer.sv
// Byte-to-32-bit word packer with valid/ready on both sides.
// Ports: clk, rst (sync, active-high); byte in: in_valid/in_ready/in_data/in_last;
// word out: out_valid/out_ready/out_data/out_keep/out_last.
module byte_word_packer #(
    parameter bit REVERSE = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [3:0]  out_keep,
    output logic        out_last
);

    logic [1:0]  cnt;
    logic [31:0] acc;
    logic [3:0]  acc_keep;
    logic        in_fire;
    logic        out_fire;
    logic        done;
    logic [1:0]  lane;
    logic [31:0] word_next;
    logic [3:0]  keep_next;

    // Stall upstream only while a word is held and downstream refuses it.
    assign in_ready = ~(out_valid & ~out_ready);
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign done     = in_fire & ((cnt == 2'd3) | in_last);

    // First byte goes to the top lane unless the word is byte-reversed.
    always_comb begin
        lane      = REVERSE ? cnt : (2'd3 - cnt);
        word_next = acc | ({24'd0, in_data} << {lane, 3'b000});
        keep_next = acc_keep | (4'b0001 << lane);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 2'd0;
            acc       <= 32'd0;
            acc_keep  <= 4'd0;
            out_valid <= 1'b0;
            out_data  <= 32'd0;
            out_keep  <= 4'd0;
            out_last  <= 1'b0;
        end else begin
            if (in_fire) begin
                if (done) begin
                    cnt       <= 2'd0;
                    acc       <= 32'd0;
                    acc_keep  <= 4'd0;
                    out_valid <= 1'b1;
                    out_data  <= word_next;
                    out_keep  <= keep_next;
                    out_last  <= in_last;
                end else begin
                    cnt      <= cnt + 2'd1;
                    acc      <= word_next;
                    acc_keep <= keep_next;
                end
            end
            // A completion in the same cycle reloads, so no bubble.
            if (out_fire && !done) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_byte_word_packer.sv
// Scoreboard bench for byte_word_packer: both REVERSE settings driven
// in parallel, expected words queued by stimulus, popped by monitors.
module tb_byte_word_packer;

    typedef logic [36:0] ent_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_ready;
    logic        rdy0, rdy1;
    logic        v0, v1;
    logic [31:0] d0, d1;
    logic [3:0]  k0, k1;
    logic        l0, l1;

    int tests = 0;
    int fails = 0;
    ent_t q0[$];
    ent_t q1[$];
    ent_t e0, e1;

    byte_word_packer #(.REVERSE(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy0),
        .in_data(in_data), .in_last(in_last),
        .out_valid(v0), .out_ready(out_ready),
        .out_data(d0), .out_keep(k0), .out_last(l0)
    );

    byte_word_packer #(.REVERSE(1'b1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .in_last(in_last),
        .out_valid(v1), .out_ready(out_ready),
        .out_data(d1), .out_keep(k1), .out_last(l1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        in_last  = l;
        while (!rdy0 && n < 50) begin
            tick();
            n++;
        end
        chk("send_ready", {63'd0, rdy0}, 64'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_word(input logic [31:0] a, input logic [3:0] ka,
                               input logic [31:0] b, input logic [3:0] kb,
                               input logic l);
        q0.push_back({l, ka, a});
        q1.push_back({l, kb, b});
    endtask

    always @(negedge clk) begin
        if (!rst && v0 && out_ready) begin
            if (q0.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_word0: got %h expected none", d0);
            end else begin
                e0 = q0.pop_front();
                chk("word_rev0", {27'd0, l0, k0, d0}, {27'd0, e0});
            end
        end
        if (!rst && v1 && out_ready) begin
            if (q1.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_word1: got %h expected none", d1);
            end else begin
                e1 = q1.pop_front();
                chk("word_rev1", {27'd0, l1, k1, d1}, {27'd0, e1});
            end
        end
    end

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", {63'd0, v0}, 64'd0);
        chk("rst_data", {32'd0, d0}, 64'd0);
        chk("rst_keep", {60'd0, k0}, 64'd0);
        chk("rst_last", {63'd0, l0}, 64'd0);
        chk("rst_ready0", {63'd0, rdy0}, 64'd1);
        chk("rst_ready1", {63'd0, rdy1}, 64'd1);
        rst = 1'b0;

        // Full word, latency of one cycle.
        send(8'd23, 1'b0);
        send(8'd42, 1'b0);
        send(8'd127, 1'b0);
        expect_word(32'h172A7FFF, 4'b1111, 32'hFF7F2A17, 4'b1111, 1'b0);
        send(8'd255, 1'b0);
        chk("latency_valid", {63'd0, v0}, 64'd1);
        chk("latency_data0", {32'd0, d0}, 64'h172A7FFF);
        chk("latency_data1", {32'd0, d1}, 64'hFF7F2A17);

        // Partial packets.
        send(8'hAA, 1'b0);
        expect_word(32'hAABB0000, 4'b1100, 32'h0000BBAA, 4'b0011, 1'b1);
        send(8'hBB, 1'b1);
        expect_word(32'h5A000000, 4'b1000, 32'h0000005A, 4'b0001, 1'b1);
        send(8'h5A, 1'b1);
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        expect_word(32'h10203000, 4'b1110, 32'h00302010, 4'b0111, 1'b1);
        send(8'h30, 1'b1);

        // Last on the fourth byte.
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b0);
        send(8'hC3, 1'b0);
        expect_word(32'hC1C2C3C4, 4'b1111, 32'hC4C3C2C1, 4'b1111, 1'b1);
        send(8'hC4, 1'b1);

        // Idle cycles mid-word.
        send(8'h31, 1'b0);
        tick();
        tick();
        tick();
        send(8'h32, 1'b0);
        send(8'h33, 1'b0);
        expect_word(32'h31323334, 4'b1111, 32'h34333231, 4'b1111, 1'b0);
        send(8'h34, 1'b0);
        tick();

        // Backpressure: word held, next byte refused.
        out_ready = 1'b0;
        send(8'h11, 1'b0);
        send(8'h12, 1'b0);
        send(8'h13, 1'b0);
        expect_word(32'h11121314, 4'b1111, 32'h14131211, 4'b1111, 1'b0);
        send(8'h14, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 5; i++) begin
            chk("stall_ready", {63'd0, rdy0}, 64'd0);
            chk("stall_data", {32'd0, d0}, 64'h11121314);
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("unstall_ready", {63'd0, rdy0}, 64'd1);
        chk("unstall_valid", {63'd0, v0}, 64'd0);
        expect_word(32'h55660000, 4'b1100, 32'h00006655, 4'b0011, 1'b1);
        send(8'h66, 1'b1);
        tick();

        // Reset mid-word discards partial bytes.
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", {63'd0, v0}, 64'd0);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        expect_word(32'h01020304, 4'b1111, 32'h04030201, 4'b1111, 1'b0);
        send(8'h04, 1'b0);
        tick();

        // Back-to-back stream, one word every four cycles.
        expect_word(32'h00010203, 4'b1111, 32'h03020100, 4'b1111, 1'b0);
        expect_word(32'h04050607, 4'b1111, 32'h07060504, 4'b1111, 1'b0);
        for (int i = 0; i < 8; i++) begin
            send(8'(i), 1'b0);
            chk("stream_valid", {63'd0, v0},
                (i == 3 || i == 7) ? 64'd1 : 64'd0);
        end
        tick();
        tick();

        // Reset drops a pending word.
        out_ready = 1'b0;
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        chk("pend_valid", {63'd0, v0}, 64'd1);
        rst = 1'b1;
        tick();
        chk("pendrst_valid", {63'd0, v0}, 64'd0);
        chk("pendrst_data", {32'd0, d0}, 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;

        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
            tick();
            n++;
        end
        tick();
        chk("drain_q0", 64'(q0.size()), 64'd0);
        chk("drain_q1", 64'(q1.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/byte_word_packer.md
BYTE_WORD_PACKER -- requirements
Module: byte_word_packer

Interface
REQ-001 The block SHALL have parameter REVERSE, default 0: 0 packs the first received byte into the most significant lane; 1 emits the byte-reversed word, equivalent to {<<8{word}}.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the upstream byte is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a byte.
REQ-006 The block SHALL have port in_data, input, 8 bits: the byte payload.
REQ-007 The block SHALL have port in_last, input, 1 bit: this byte ends the current packet.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the packed word is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream accepts the word.
REQ-010 The block SHALL have port out_data, output, 32 bits: the packed word.
REQ-011 The block SHALL have port out_keep, output, 4 bits: keep[i] set means byte lane out_data[8i+7:8i] holds a received byte.
REQ-012 The block SHALL have port out_last, output, 1 bit: this word ends the packet.

Function
REQ-013 Input transfer SHALL occur when in_valid and in_ready are both high at a rising edge; output transfer SHALL occur when out_valid and out_ready are both high at a rising edge.
REQ-014 in_ready SHALL equal NOT(out_valid AND NOT out_ready), combinationally.
REQ-015 The block SHALL keep a 2-bit byte counter, 0..3, giving the lane index of the next byte within the accumulating word.
REQ-016 With REVERSE=0, byte k of a word (k=0 first) SHALL land in bits [31-8k:24-8k]; with REVERSE=1 it SHALL land in bits [8k+7:8k].
REQ-017 A word SHALL complete when the accepted byte has counter==3 or in_last==1.
REQ-018 On completion, the completed word SHALL be loaded into the output register and out_valid SHALL be high in the next cycle, giving a latency of 1 cycle from the completing byte.
REQ-019 On completion, the counter SHALL return to 0 and the accumulator SHALL clear.
REQ-020 Unfilled lanes of a partial word SHALL read 0x00 and have the matching keep bit 0.
REQ-021 keep SHALL be 4'b1111 for a full word; for a partial word of n bytes it SHALL be the top n lanes (REVERSE=0) or the bottom n lanes (REVERSE=1).
REQ-022 out_last SHALL be 1 only when the word was completed by a byte with in_last=1, including in_last on the 4th byte (full word, keep=4'b1111, last=1).
REQ-023 While out_valid=1 and out_ready=0, out_data, out_keep and out_last SHALL hold stable and no byte SHALL be accepted.
REQ-024 On an output transfer with no completion in the same cycle, out_valid SHALL fall next cycle.
REQ-025 An output transfer and a new completion in the same cycle SHALL load the new word, so out_valid stays high with no bubble.
REQ-026 With in_valid held high and out_ready held high, the block SHALL emit one word per 4 input cycles with no stall.
REQ-027 A cycle with in_valid=0 SHALL leave the counter and accumulator unchanged.

Reset
REQ-028 While rst=1, out_valid, out_data, out_keep, out_last, the counter and the accumulator SHALL all be 0.
REQ-029 While rst=1, in_ready SHALL read 1 per REQ-014.
REQ-030 Reset mid-word SHALL discard the partial bytes, and the first byte after reset SHALL be byte 0 of a new word.
REQ-031 Reset while out_valid=1 SHALL drop the pending word.

Verification
REQ-032 REVERSE=0, bytes 23,42,127,255, out_ready=1 -> one cycle after the 4th byte: out_data=0x172A7FFF, keep=4'b1111, last=0.
REQ-033 REVERSE=1, same bytes -> out_data=0xFF7F2A17, keep=4'b1111.
REQ-034 REVERSE=0, bytes 0xAA, then 0xBB with in_last -> out_data=0xAABB0000, keep=4'b1100, last=1; with REVERSE=1 -> 0x0000BBAA, keep=4'b0011.
REQ-035 Word pending, out_ready=0 for 5 cycles -> in_ready=0 and out_data stable throughout; out_ready=1 -> transfer, in_ready=1 next cycle.
REQ-036 After 2 bytes, assert rst for 1 cycle, then send bytes 0x01..0x04 -> out_data=0x01020304, keep=4'b1111.
REQ-037 8 back-to-back bytes 0x00..0x07, out_ready=1 -> words 0x00010203 then 0x04050607, out_valid pulses 4 cycles apart.
